// File: rtl/motion_pkg.sv
// Shared types and helpers for the motion sequencer.
package motion_pkg;

  localparam int WIDTH_DEF = 16;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    RAMP   = 3'd1,
    SETTLE = 3'd2,
    HOLD   = 3'd3,
    FAULT  = 3'd4
  } state_t;

  // |v| <= lim for a sign-extended difference (WIDTH+1 <= 33 bits).
  // The magnitude is formed one bit wider so that the most negative value
  // cannot overflow.
  function automatic logic mag_le(input logic signed [32:0] v,
                                  input logic [31:0] lim);
    logic signed [33:0] a;
    a = 34'(v);
    if (a < 0) a = -a;
    return a <= $signed({2'b00, lim});
  endfunction

endpackage

// File: rtl/motion_sequencer_tick_gen.sv
// Free-running tick divider: strobe on the last count, then wrap to zero.
module tick_gen #(
  parameter int TICK_DIV = 12000
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic strobe
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt;

  assign strobe = (cnt == LAST);

  // Count 0..TICK_DIV-1; clear holds the phase at zero.
  always_ff @(posedge clk) begin
    if (rst || clear) cnt <= '0;
    else if (strobe)  cnt <= '0;
    else              cnt <= cnt + CW'(1);
  end

endmodule

// File: rtl/motion_sequencer.sv
// Supervisory setpoint sequencer for pid_16: rate-limited ramp toward the
// requested target, settle monitoring with timeout, and PID reset control.
module motion_sequencer
  import motion_pkg::*;
#(
  parameter int WIDTH         = WIDTH_DEF,
  parameter int TICK_DIV      = 12000,
  parameter int STEP_MAX      = 4,
  parameter int SETTLE_BAND   = 8,
  parameter int SETTLE_TICKS  = 50,
  parameter int TIMEOUT_TICKS = 2000
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    enable,
  input  logic signed [WIDTH-1:0] target,
  input  logic                    target_valid,
  input  logic signed [WIDTH-1:0] position,
  output logic signed [WIDTH-1:0] setpoint_out,
  output logic                    pid_rst,
  output logic                    busy,
  output logic                    settled,
  output logic                    fault
);

  localparam int SW = $clog2(SETTLE_TICKS + 1);
  localparam int TW = $clog2(TIMEOUT_TICKS + 1);

  state_t                  state;
  logic signed [WIDTH-1:0] tgt;
  logic [SW-1:0]           settle_cnt, settle_nxt;
  logic [TW-1:0]           timeout_cnt, timeout_nxt;
  logic                    tick, tick_clr;
  logic signed [WIDTH:0]   diff, err;
  logic                    step_done, in_band;

  // Holding the divider at zero while idle makes the first ramp step land
  // exactly TICK_DIV cycles after leaving IDLE.
  assign tick_clr = (state == IDLE);

  tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk    (clk),
    .rst    (rst),
    .clear  (tick_clr),
    .strobe (tick)
  );

  // Status is a pure decode of the registered state.
  assign pid_rst = (state == IDLE) || (state == FAULT);
  assign busy    = (state == RAMP) || (state == SETTLE);
  assign settled = (state == HOLD);
  assign fault   = (state == FAULT);

  // Ramp/settle arithmetic at WIDTH+1 bits so full-scale spans never wrap.
  always_comb begin
    diff      = {tgt[WIDTH-1], tgt} - {setpoint_out[WIDTH-1], setpoint_out};
    err       = {tgt[WIDTH-1], tgt} - {position[WIDTH-1], position};
    step_done = mag_le(33'(diff), 32'(STEP_MAX));
    in_band   = mag_le(33'(err), 32'(SETTLE_BAND));
    if (!in_band)                             settle_nxt = '0;
    else if (settle_cnt == SW'(SETTLE_TICKS)) settle_nxt = settle_cnt;
    else                                      settle_nxt = settle_cnt + SW'(1);
    if (timeout_cnt == TW'(TIMEOUT_TICKS))    timeout_nxt = timeout_cnt;
    else                                      timeout_nxt = timeout_cnt + TW'(1);
  end

  // Sequencer FSM and setpoint datapath: rst > enable > target_valid > tick.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      setpoint_out <= '0;
      tgt          <= '0;
      settle_cnt   <= '0;
      timeout_cnt  <= '0;
    end else if (!enable) begin
      if (state == IDLE) setpoint_out <= position;
      state <= IDLE;
    end else if (target_valid && state != FAULT) begin
      if (state == IDLE) setpoint_out <= position;
      tgt   <= target;
      state <= RAMP;
    end else begin
      case (state)
        IDLE: setpoint_out <= position;
        RAMP: if (tick) begin
          if (step_done) begin
            setpoint_out <= tgt;
            settle_cnt   <= '0;
            timeout_cnt  <= '0;
            state        <= SETTLE;
          end else if (diff[WIDTH]) begin
            setpoint_out <= setpoint_out - WIDTH'(STEP_MAX);
          end else begin
            setpoint_out <= setpoint_out + WIDTH'(STEP_MAX);
          end
        end
        SETTLE: if (tick) begin
          settle_cnt  <= settle_nxt;
          timeout_cnt <= timeout_nxt;
          if (settle_nxt == SW'(SETTLE_TICKS))       state <= HOLD;
          else if (timeout_nxt == TW'(TIMEOUT_TICKS)) state <= FAULT;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_motion_sequencer.sv
// Randomized + directed bench for motion_sequencer against a behavioural model.
module tb_motion_sequencer;

  localparam int W  = 16;
  localparam int TD = 4;
  localparam int SM = 4;
  localparam int SB = 2;
  localparam int ST = 3;
  localparam int TO = 10;

  localparam int M_IDLE = 0, M_RAMP = 1, M_SETTLE = 2, M_HOLD = 3, M_FAULT = 4;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic                enable = 1'b0;
  logic                target_valid = 1'b0;
  logic signed [W-1:0] target = '0;
  logic signed [W-1:0] position = '0;
  logic signed [W-1:0] setpoint_out;
  logic                pid_rst, busy, settled, fault;

  always #5 clk = ~clk;

  motion_sequencer #(
    .WIDTH(W), .TICK_DIV(TD), .STEP_MAX(SM), .SETTLE_BAND(SB),
    .SETTLE_TICKS(ST), .TIMEOUT_TICKS(TO)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable), .target(target),
    .target_valid(target_valid), .position(position),
    .setpoint_out(setpoint_out), .pid_rst(pid_rst), .busy(busy),
    .settled(settled), .fault(fault)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- behavioural reference model ----------------
  int m_mode = M_IDLE, m_sp = 0, m_tgt = 0, m_phase = 0, m_in = 0, m_el = 0;
  bit started = 1'b0;

  function automatic int iabs(input int x);
    return (x < 0) ? -x : x;
  endfunction

  function automatic int imin(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  task automatic model_step();
    bit tk_now;
    int d;
    started = 1'b1;
    if (rst) begin
      m_mode = M_IDLE; m_sp = 0; m_tgt = 0; m_phase = 0; m_in = 0; m_el = 0;
      return;
    end
    tk_now  = (m_phase == TD - 1);
    m_phase = (m_phase + 1) % TD;
    if (!enable) begin
      if (m_mode == M_IDLE) m_sp = int'(position);
      m_mode = M_IDLE;
    end else if (target_valid && m_mode != M_FAULT) begin
      if (m_mode == M_IDLE) begin
        m_sp    = int'(position);
        m_phase = 0;
      end
      m_tgt  = int'(target);
      m_mode = M_RAMP;
    end else if (m_mode == M_IDLE) begin
      m_sp = int'(position);
    end else if (m_mode == M_RAMP && tk_now) begin
      d = m_tgt - m_sp;
      if (iabs(d) <= SM) begin
        m_sp = m_tgt; m_mode = M_SETTLE; m_in = 0; m_el = 0;
      end else begin
        m_sp = m_sp + ((d > 0) ? SM : -SM);
      end
    end else if (m_mode == M_SETTLE && tk_now) begin
      m_in = (iabs(m_tgt - int'(position)) <= SB) ? imin(m_in + 1, ST) : 0;
      m_el = imin(m_el + 1, TO);
      if (m_in >= ST)      m_mode = M_HOLD;
      else if (m_el >= TO) m_mode = M_FAULT;
    end
  endtask

  always @(posedge clk) model_step();

  // Compare every output against the model, away from the active edge.
  always @(negedge clk) begin
    if (started) begin
      chk("sp",      int'(setpoint_out), m_sp);
      chk("busy",    int'(busy),    int'(m_mode == M_RAMP || m_mode == M_SETTLE));
      chk("settled", int'(settled), int'(m_mode == M_HOLD));
      chk("fault",   int'(fault),   int'(m_mode == M_FAULT));
      chk("pid_rst", int'(pid_rst), int'(m_mode == M_IDLE || m_mode == M_FAULT));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic strobe(input int t);
    target       = W'(t);
    target_valid = 1'b1;
    @(negedge clk);
    target_valid = 1'b0;
  endtask

  initial begin
    int p, t, i;
    // Reset, then bumpless tracking in IDLE.
    rst = 1'b1; enable = 1'b1; position = 16'sd5;
    tk(3);
    rst = 1'b0;
    tk(3);
    chk("idle_track", int'(setpoint_out), 5);
    chk("idle_pidrst", int'(pid_rst), 1);

    // Short ramp 0 -> 10, then settle at position 9.
    position = 16'sd0;
    tk(2);
    strobe(10);
    chk("busy_latency", int'(busy), 1);
    position = 16'sd9;
    tk(28);
    chk("hold_settled", int'(settled), 1);
    chk("hold_sp", int'(setpoint_out), 10);

    // Negative ramp with a mid-ramp retarget.
    enable = 1'b0; tk(1); position = 16'sd0; tk(2); enable = 1'b1; tk(1);
    strobe(-100);
    for (i = 0; i < 200 && int'(setpoint_out) != -40; i++) tk(1);
    chk("reach_m40", int'(setpoint_out), -40);
    strobe(-30);
    tk(24);
    chk("retarget_sp", int'(setpoint_out), -30);

    // Out-of-band settle -> FAULT; strobes ignored; enable low clears it.
    position = 16'sd20;
    strobe(10);
    tk(100);
    chk("fault_set", int'(fault), 1);
    chk("fault_pidrst", int'(pid_rst), 1);
    strobe(20);
    tk(8);
    chk("fault_sticky", int'(fault), 1);
    enable = 1'b0; tk(1);
    chk("fault_clear", int'(fault), 0);

    // Boundary single steps at both ends of the range.
    position = 16'sd32765; tk(2); enable = 1'b1; tk(1);
    strobe(32767);
    tk(4);
    chk("max_step", int'(setpoint_out), 32767);
    position = -16'sd32768;
    tk(50);
    chk("fullscale_err_fault", int'(fault), 1);
    enable = 1'b0; position = -16'sd32766; tk(2); enable = 1'b1; tk(1);
    strobe(-32768);
    tk(4);
    chk("min_step", int'(setpoint_out), -32768);
    position = -16'sd32768;
    tk(14);
    chk("min_settled", int'(settled), 1);

    // enable low together with target_valid mid-RAMP.
    strobe(0);
    tk(5);
    enable = 1'b0; target = 16'sd500; target_valid = 1'b1;
    tk(1);
    target_valid = 1'b0;
    chk("dis_idle_busy", int'(busy), 0);
    enable = 1'b1;
    tk(3);
    chk("dis_no_latch", int'(busy), 0);

    // Reset mid-RAMP.
    position = 16'sd100; tk(1);
    strobe(300);
    tk(9);
    rst = 1'b1; tk(1);
    chk("rst_sp", int'(setpoint_out), 0);
    chk("rst_pidrst", int'(pid_rst), 1);
    chk("rst_busy", int'(busy), 0);
    rst = 1'b0;

    // Randomized traffic.
    for (int n = 0; n < 3000; n++) begin
      rst          = ($urandom % 600) == 0;
      enable       = ($urandom % 80) != 0;
      target_valid = ($urandom % 24) == 0;
      if (($urandom % 8) == 0) t = int'($urandom_range(0, 65535)) - 32768;
      else                     t = int'(setpoint_out) + int'($urandom_range(0, 80)) - 40;
      if (t > 32767) t = 32767;
      if (t < -32768) t = -32768;
      target = W'(t);
      if (($urandom % 50) == 0) p = int'($urandom_range(0, 65535)) - 32768;
      else                      p = int'(setpoint_out) + int'($urandom_range(0, 6)) - 3;
      if (p > 32767) p = 32767;
      if (p < -32768) p = -32768;
      position = W'(p);
      tk(1);
    end
    rst = 1'b0; target_valid = 1'b0;
    tk(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/motion_sequencer.md
Name: motion_sequencer

Overview:
- Supervisory controller that sits between the SPI setpoint receiver and pid_16, and feeds pid_16's setpoint input.
- Rate-limits the commanded setpoint toward a requested target in fixed ticks.
- Holds the PID in reset while idle or faulted, and reports busy, settled and fault status.
- Makes large SPI setpoint steps produce a bounded motion profile instead of a full-scale error step.

Parameters:
- WIDTH, 16, width of target, position and setpoint (signed).
- TICK_DIV, 12000, clk cycles per ramp/settle tick (500 Hz at 6 MHz).
- STEP_MAX, 4, maximum setpoint change per tick (counts); must be ≥1.
- SETTLE_BAND, 8, allowed |target − position| for counting toward settled.
- SETTLE_TICKS, 50, consecutive in-band ticks required to declare settled.
- TIMEOUT_TICKS, 2000, maximum ticks allowed in SETTLE before fault.

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous, active-high reset.
- enable  input  1  level; low forces IDLE.
- target  input  WIDTH  signed requested position.
- target_valid  input  1  one-cycle strobe qualifying target.
- position  input  WIDTH  signed encoder position from quadrature_decoder.
- setpoint_out  output  WIDTH  signed commanded setpoint to pid_16, registered.
- pid_rst  output  1  drives pid_16 reset, OR'd with rst at the top level.
- busy  output  1  high in RAMP or SETTLE.
- settled  output  1  high in HOLD.
- fault  output  1  high in FAULT.

Behaviour:
- Decided: one clock; reset is synchronous and active-high; ports are clk and rst.
- Reset: state=IDLE, setpoint_out=0, latched target=0, tick/settle/timeout counters=0, pid_rst=1, busy=0, settled=0, fault=0. Reset mid-operation aborts immediately with the same values.
- Status outputs are decoded from the registered state only (no combinational path from inputs).
- Priority each cycle: rst > enable low > target_valid > tick actions.
- enable low in any state: next state IDLE. Simultaneous target_valid is ignored.
- IDLE:
  - pid_rst=1; setpoint_out<=position every cycle (bumpless start).
  - enable & target_valid: latch target, clear the tick counter, go RAMP. pid_rst=0 and busy=1 from the next cycle (1-cycle latency).
- Tick: an internal counter counts 0..TICK_DIV−1. The strobe occurs on the cycle the counter equals TICK_DIV−1, then the counter wraps to 0. The first step therefore comes TICK_DIV cycles after entering RAMP.
- RAMP, on each tick:
  - diff = target − setpoint_out, computed at WIDTH+1 bits.
  - If |diff| ≤ STEP_MAX: setpoint_out<=target, go SETTLE, clear the settle and timeout counters.
  - Else: setpoint_out ± STEP_MAX toward target. No wrap is possible because target is in range.
- SETTLE, on each tick:
  - err = target − position at WIDTH+1 bits; in-band test is |err| ≤ SETTLE_BAND.
  - In band: increment settle_cnt; otherwise clear it.
  - timeout_cnt increments every tick.
  - settle_cnt reaching SETTLE_TICKS → HOLD.
  - Otherwise timeout_cnt reaching TIMEOUT_TICKS → FAULT.
  - If both reach their limits on the same tick, HOLD wins.
- HOLD: setpoint_out constant; settled=1; no band monitoring.
- target_valid in RAMP, SETTLE or HOLD (enable high):
  - Latch the new target and go/stay RAMP, stepping from the current setpoint_out.
  - The tick counter is not cleared.
  - target equal to setpoint_out still passes through RAMP → SETTLE on the next tick.
- FAULT: pid_rst=1, fault=1, setpoint_out frozen, target_valid ignored. Exit only via enable low → IDLE.
- Counter widths:
  - tick counter: $clog2(TICK_DIV).
  - settle counter: $clog2(SETTLE_TICKS+1).
  - timeout counter: $clog2(TIMEOUT_TICKS+1).
  - Settle and timeout counters saturate and never wrap.

Decomposition:
- motion_pkg:
  - state enum (IDLE, RAMP, SETTLE, HOLD, FAULT).
  - WIDTH default.
  - a shared abs/compare helper function for WIDTH+1-bit signed magnitude.
- Sub-module tick_gen (parameter TICK_DIV; ports clk, rst, clear, strobe) produces the tick strobe; the FSM and datapath stay in motion_sequencer.

Test Plan (bench params: TICK_DIV=4, STEP_MAX=4, SETTLE_BAND=2, SETTLE_TICKS=3, TIMEOUT_TICKS=10):
- Reset, enable=1, position=5, no target → setpoint_out=5 tracks position, pid_rst=1, busy=0, settled=0, fault=0.
- Position=0, target=10 strobed → busy=1 next cycle; setpoint_out 0→4→8→10 on ticks 4 cycles apart; then SETTLE. Position held at 9 → settled=1 after 3 ticks.
- Target=−100 from setpoint 0: setpoint_out steps by −4 per tick, never overshoots −100. Mid-ramp at −40, strobe target=−30 → ramps up to −32 then −30, then SETTLE.
- In SETTLE, hold position=20 with target=10 → fault=1 and pid_rst=1 after 10 ticks. target_valid is ignored while faulted. enable=0 → IDLE and fault clears next cycle.
- Boundary: target=32767 from position 32765, and target=−32768 from −32766 → single step lands exactly on target with no wrap. Err from position −32768 to target 32767 is computed without overflow (out of band).
- Simultaneous enable=0 and target_valid in RAMP → IDLE, target not latched. rst asserted mid-RAMP → all reset values next cycle.
